// File: rtl/fetch_buffer.sv
// Instruction-fetch stage: owns the PC, runs one bus transaction at a time and
// queues fetched instructions for decode behind a valid/ready handshake.
package fetch_buffer_pkg;
   typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } ibus_req_t;

   typedef struct packed {
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;
endpackage

// state      | meaning
// ST_RUN     | fetching at pc while the queue has room
// ST_DISCARD | finishing a transaction made stale by a redirect; its data is dropped
module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output ibus_req_t   ireq,
   input  ibus_resp_t  iresp,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [31:0] out_instr,
   output logic        stallI
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {ST_RUN, ST_DISCARD} state_t;

   state_t          r_state, w_state_nxt;
   logic [63:0]     r_pc, r_pend_addr;
   logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
   logic [CW-1:0]   r_count;
   logic [63:0]     r_mem_pc    [DEPTH];
   logic [31:0]     r_mem_instr [DEPTH];
   logic            w_push, w_pop, w_to_discard;
   logic [63:0]     w_redir_pc;

   assign w_redir_pc = redirect_pc & ~64'd3;

   always_comb begin
      w_state_nxt  = r_state;
      w_push       = 1'b0;
      w_to_discard = 1'b0;
      ireq         = '0;
      ireq.size    = MSIZE4;
      case (r_state)
         ST_RUN: begin
            // Count only rises on data_ok, so a raised valid cannot drop before it.
            ireq.valid   = (r_count < CW'(DEPTH)) && !reset;
            ireq.addr    = r_pc;
            w_push       = ireq.valid && iresp.data_ok && !redirect_valid;
            w_to_discard = redirect_valid && ireq.valid && !iresp.data_ok;
            if (w_to_discard) w_state_nxt = ST_DISCARD;
         end
         ST_DISCARD: begin
            ireq.valid = !reset;
            ireq.addr  = r_pend_addr;
            if (iresp.data_ok) w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   assign w_pop = out_valid && out_ready && !redirect_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_RUN;
         r_pc        <= RESET_PC;
         r_pend_addr <= '0;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (redirect_valid) begin
            r_pc     <= w_redir_pc;
            r_count  <= '0;
            r_rd_ptr <= r_wr_ptr;
            if (w_to_discard) r_pend_addr <= r_pc;
         end else begin
            if (w_push) begin
               r_pc     <= r_pc + 64'd4;
               r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_pc[r_wr_ptr]    <= r_pc;
         r_mem_instr[r_wr_ptr] <= iresp.data;
      end
   end

   assign out_valid = (r_count != '0);
   assign out_pc    = r_mem_pc[r_rd_ptr];
   assign out_instr = r_mem_instr[r_rd_ptr];
   assign stallI    = !out_valid;
endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Parametrised instruction-fetch stage that owns the PC, issues requests on the instruction bus, and decouples the bus from decode through a DEPTH-entry instruction queue with a valid/ready output handshake. It replaces the single-cycle fetch wrapper in the pipeline front end. Unlike that wrapper, it keeps fetching while decode stalls and accepts redirects from execute or commit. A redirect that arrives mid-transaction is handled by completing and discarding the stale response.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 64'h8000_0000: PC loaded on reset.
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-high reset.
- ireq  output  ibus_req_t  instruction bus request.
  - Fields driven: valid, addr; size = MSIZE4; strobe = 0; data = 0.
- iresp  input  ibus_resp_t  instruction bus response; fields used: data_ok, data (32 bits).
- redirect_valid  input  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  input  64  new fetch address; bits [1:0] ignored (treated as 0).
- out_valid  output  1  queue head is valid.
- out_ready  input  1  decode accepts the head this cycle.
- out_pc  output  64  PC of the head entry.
- out_instr  output  32  raw instruction of the head entry.
- stallI  output  1  1 when out_valid = 0 (front-end bubble indicator for hazard logic).

## Operation
- State: pc (64), pend_addr (64), rd_ptr/wr_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count ($clog2(DEPTH+1) bits), FSM {RUN, DISCARD}.
- Bus rule: once ireq.valid is 1, valid and addr hold unchanged until the cycle data_ok = 1. Exactly one transaction is outstanding at a time; data_ok may arrive in the same cycle valid rises.
- RUN:
  - ireq.valid = (count < DEPTH); ireq.addr = pc. Count cannot rise without data_ok, so valid stays held.
  - data_ok and no redirect: push {pc, iresp.data} at wr_ptr, then pc <= pc + 4.
  - redirect with ireq.valid and data_ok both 1: response dropped, no push, pc <= redirect_pc, stay RUN.
  - redirect with ireq.valid = 1 and data_ok = 0: pend_addr <= pc, pc <= redirect_pc, go to DISCARD.
  - redirect with ireq.valid = 0: pc <= redirect_pc.
- DISCARD:
  - ireq.valid = 1; ireq.addr = pend_addr.
  - On data_ok: data dropped, go to RUN.
  - A further redirect only updates pc; the FSM stays in or returns to RUN per data_ok.
- Queue:
  - Pop when out_valid and out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pop on empty is ignored.
  - out_pc and out_instr are the entry at rd_ptr; they are don't-care when out_valid = 0.
- Redirect priority: flush over push over pop. On redirect, count <= 0 and rd_ptr <= wr_ptr. A pop asserted in the same cycle is discarded.
- pc arithmetic: 64-bit, wraps modulo 2^64.

## Timing
- Reset (asynchronous, takes effect immediately):
  - pc = RESET_PC, count = 0, pointers = 0, state = RUN.
  - out_valid = 0, stallI = 1.
  - ireq.valid is forced to 0 while reset = 1; after reset deasserts it becomes 1 combinationally.
  - Reset asserted mid-transaction abandons the transaction; the bus is reset with the core.
- Fill latency: data_ok in cycle t gives out_valid = 1 in cycle t+1.
- Redirect latency: redirect in cycle t gives ireq.addr = redirect_pc in cycle t+1 from RUN, or after the stale data_ok from DISCARD. out_valid = 0 in cycle t+1.
- Full queue (count = DEPTH): ireq.valid = 0. A pop in cycle t re-raises valid in cycle t+1.
- Throughput: one instruction per cycle with a zero-wait bus and out_ready held at 1.

## Test plan
- Reset then zero-wait bus, out_ready = 1: ireq.addr sequence 8000_0000, 8000_0004, 8000_0008. out_valid first rises the cycle after the first data_ok; out_pc/out_instr match in order.
- out_ready = 0, DEPTH = 4, zero-wait bus: exactly 4 pushes, count = 4, ireq.valid = 0. One pop gives valid = 1 the next cycle with addr 8000_0010.
- Bus with 3-cycle wait: ireq.valid and addr stay stable for all wait cycles; no push until data_ok.
- Redirect to 8000_1000 in wait cycle 1 of a request to 8000_0004:
  - addr stays 8000_0004 until data_ok, and that data never appears at the output.
  - The next request addr is 8000_1000; the queue is empty the cycle after the redirect.
- Redirect coincident with data_ok and with a pop: no push, count = 0 next cycle, next addr = redirect_pc.
- Reset asserted mid-queue (count = 3): out_valid = 0 and ireq.valid = 0 immediately. After release, fetch restarts at RESET_PC.
